// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath sizes and ALU opcode encoding used by the
// decode and execute stages.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // True for the three shifter opcodes, whose operand B is only a shift amount
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register. EX/MEM wins over
// MEM/WB, and x0 always reads the register file so it stays zero.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int XLEN    = cpu_pkg::XLEN,
    parameter int RADDR_W = cpu_pkg::RADDR_W
) (
    input  logic [RADDR_W-1:0] addr,
    input  logic [XLEN-1:0]    rf_data,
    input  logic               exmem_we,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic               memwb_we,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]    memwb_result,
    output logic [XLEN-1:0]    data
);

    // Pick the youngest in-flight producer of this register, else the RF value
    always_comb begin
        data = rf_data;
        if (addr != '0) begin
            if (exmem_we && (exmem_rd == addr)) begin
                data = exmem_result;
            end else if (memwb_we && (memwb_rd == addr)) begin
                data = memwb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: resolves forwarding and operand B selection at
// capture time, then presents registered operands to the execute stage.
// Supports stall (hold) and flush (bubble) with flush taking priority.
module id_ex_reg
    import cpu_pkg::*;
#(
    parameter int XLEN    = cpu_pkg::XLEN,
    parameter int RADDR_W = cpu_pkg::RADDR_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               id_valid_i,
    input  logic [XLEN-1:0]    id_pc_i,
    input  logic [XLEN-1:0]    id_rs1_data_i,
    input  logic [XLEN-1:0]    id_rs2_data_i,
    input  logic [XLEN-1:0]    id_imm_i,
    input  logic [RADDR_W-1:0] id_rs1_addr_i,
    input  logic [RADDR_W-1:0] id_rs2_addr_i,
    input  logic [RADDR_W-1:0] id_rd_addr_i,
    input  logic [3:0]         id_alu_op_i,
    input  logic               id_src_b_imm_i,
    input  logic               id_reg_we_i,
    input  logic               exmem_we_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]    exmem_result_i,
    input  logic               memwb_we_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]    memwb_result_i,
    output logic               ex_valid_o,
    output logic [XLEN-1:0]    ex_pc_o,
    output logic [XLEN-1:0]    ex_a_o,
    output logic [XLEN-1:0]    ex_b_o,
    output logic [XLEN-1:0]    ex_store_data_o,
    output logic [RADDR_W-1:0] ex_rd_addr_o,
    output logic [3:0]         ex_alu_op_o,
    output logic               ex_reg_we_o
);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] b_raw;
    logic [XLEN-1:0] b_next;

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
        .addr         (id_rs1_addr_i),
        .rf_data      (id_rs1_data_i),
        .exmem_we     (exmem_we_i),
        .exmem_rd     (exmem_rd_i),
        .exmem_result (exmem_result_i),
        .memwb_we     (memwb_we_i),
        .memwb_rd     (memwb_rd_i),
        .memwb_result (memwb_result_i),
        .data         (fwd_a)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
        .addr         (id_rs2_addr_i),
        .rf_data      (id_rs2_data_i),
        .exmem_we     (exmem_we_i),
        .exmem_rd     (exmem_rd_i),
        .exmem_result (exmem_result_i),
        .memwb_we     (memwb_we_i),
        .memwb_rd     (memwb_rd_i),
        .memwb_result (memwb_result_i),
        .data         (fwd_b)
    );

    // Operand B: immediate or forwarded rs2, trimmed to a shift amount for shifts
    always_comb begin
        b_raw  = id_src_b_imm_i ? id_imm_i : fwd_b;
        b_next = b_raw;
        if (is_shift_op(id_alu_op_i)) begin
            b_next = {{(XLEN-SHAMT_W){1'b0}}, b_raw[SHAMT_W-1:0]};
        end
    end

    // Pipeline register with priority reset > flush > stall > load
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_o      <= 1'b0;
            ex_pc_o         <= '0;
            ex_a_o          <= '0;
            ex_b_o          <= '0;
            ex_store_data_o <= '0;
            ex_rd_addr_o    <= '0;
            ex_alu_op_o     <= ALU_ADD;
            ex_reg_we_o     <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o      <= 1'b0;
            ex_pc_o         <= '0;
            ex_a_o          <= '0;
            ex_b_o          <= '0;
            ex_store_data_o <= '0;
            ex_rd_addr_o    <= '0;
            ex_alu_op_o     <= ALU_ADD;
            ex_reg_we_o     <= 1'b0;
        end else if (!stall_i) begin
            ex_valid_o      <= id_valid_i;
            ex_pc_o         <= id_pc_i;
            ex_a_o          <= fwd_a;
            ex_b_o          <= b_next;
            ex_store_data_o <= fwd_b;
            ex_rd_addr_o    <= id_rd_addr_i;
            ex_alu_op_o     <= id_alu_op_i;
            ex_reg_we_o     <= id_reg_we_i & id_valid_i;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed vector table, hand-written
// stall/flush/reset sequences, and randomized traffic against a reference model.
module tb_id_ex_reg;
    import cpu_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [3:0]  alu_op;
        logic        src_b_imm;
        logic        reg_we;
        logic        exmem_we;
        logic [4:0]  exmem_rd;
        logic [31:0] exmem_result;
        logic        memwb_we;
        logic [4:0]  memwb_rd;
        logic [31:0] memwb_result;
    } id_in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        we;
    } ex_state_t;

    typedef struct {
        id_in_t    in;
        ex_state_t exp;
        string     name;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic        id_valid_i;
    logic [31:0] id_pc_i;
    logic [31:0] id_rs1_data_i;
    logic [31:0] id_rs2_data_i;
    logic [31:0] id_imm_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic [4:0]  id_rd_addr_i;
    logic [3:0]  id_alu_op_i;
    logic        id_src_b_imm_i;
    logic        id_reg_we_i;
    logic        exmem_we_i;
    logic [4:0]  exmem_rd_i;
    logic [31:0] exmem_result_i;
    logic        memwb_we_i;
    logic [4:0]  memwb_rd_i;
    logic [31:0] memwb_result_i;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o;
    logic [31:0] ex_a_o;
    logic [31:0] ex_b_o;
    logic [31:0] ex_store_data_o;
    logic [4:0]  ex_rd_addr_o;
    logic [3:0]  ex_alu_op_o;
    logic        ex_reg_we_o;

    int checks   = 0;
    int failures = 0;

    id_in_t    cur_in;
    logic      cur_stall;
    logic      cur_flush;
    ex_state_t model;
    vec_t      vecs[8];

    id_ex_reg dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .id_valid_i      (id_valid_i),
        .id_pc_i         (id_pc_i),
        .id_rs1_data_i   (id_rs1_data_i),
        .id_rs2_data_i   (id_rs2_data_i),
        .id_imm_i        (id_imm_i),
        .id_rs1_addr_i   (id_rs1_addr_i),
        .id_rs2_addr_i   (id_rs2_addr_i),
        .id_rd_addr_i    (id_rd_addr_i),
        .id_alu_op_i     (id_alu_op_i),
        .id_src_b_imm_i  (id_src_b_imm_i),
        .id_reg_we_i     (id_reg_we_i),
        .exmem_we_i      (exmem_we_i),
        .exmem_rd_i      (exmem_rd_i),
        .exmem_result_i  (exmem_result_i),
        .memwb_we_i      (memwb_we_i),
        .memwb_rd_i      (memwb_rd_i),
        .memwb_result_i  (memwb_result_i),
        .ex_valid_o      (ex_valid_o),
        .ex_pc_o         (ex_pc_o),
        .ex_a_o          (ex_a_o),
        .ex_b_o          (ex_b_o),
        .ex_store_data_o (ex_store_data_o),
        .ex_rd_addr_o    (ex_rd_addr_o),
        .ex_alu_op_o     (ex_alu_op_o),
        .ex_reg_we_o     (ex_reg_we_o)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk_i = ~clk_i;

    function automatic id_in_t make_in(
        input logic v, input logic [31:0] pc, input logic [31:0] r1d, input logic [31:0] r2d,
        input logic [31:0] imm, input logic [4:0] r1a, input logic [4:0] r2a, input logic [4:0] rda,
        input logic [3:0] op, input logic sbi, input logic we,
        input logic xwe, input logic [4:0] xrd, input logic [31:0] xres,
        input logic mwe, input logic [4:0] mrd, input logic [31:0] mres);
        id_in_t r;
        r = '{v, pc, r1d, r2d, imm, r1a, r2a, rda, op, sbi, we, xwe, xrd, xres, mwe, mrd, mres};
        return r;
    endfunction

    function automatic ex_state_t make_exp(
        input logic v, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] st, input logic [4:0] rd, input logic [3:0] op, input logic we);
        ex_state_t r;
        r = '{v, pc, a, b, st, rd, op, we};
        return r;
    endfunction

    // Newest producer of a register wins; x0 is hardwired so never forwarded
    function automatic logic [31:0] forward(input id_in_t in, input logic [4:0] addr, input logic [31:0] rf);
        if (addr == 0) return rf;
        if (in.exmem_we && in.exmem_rd == addr) return in.exmem_result;
        if (in.memwb_we && in.memwb_rd == addr) return in.memwb_result;
        return rf;
    endfunction

    // Reference behaviour of one clock edge (reset handled by the caller)
    function automatic ex_state_t model_next(input ex_state_t cur, input id_in_t in,
                                             input logic stall, input logic flush);
        ex_state_t n;
        logic [31:0] rs2v;
        if (flush) return '0;
        if (stall) return cur;
        rs2v    = forward(in, in.rs2_addr, in.rs2_data);
        n.valid = in.valid;
        n.pc    = in.pc;
        n.a     = forward(in, in.rs1_addr, in.rs1_data);
        n.b     = in.src_b_imm ? in.imm : rs2v;
        if (in.alu_op == ALU_SLL || in.alu_op == ALU_SRL || in.alu_op == ALU_SRA)
            n.b = n.b % 32;
        n.store = rs2v;
        n.rd    = in.rd_addr;
        n.op    = in.alu_op;
        n.we    = in.valid && in.reg_we;
        return n;
    endfunction

    function automatic id_in_t random_in();
        id_in_t r;
        r.valid        = ($urandom_range(0, 9) != 0);
        r.pc           = $urandom;
        r.rs1_data     = $urandom;
        r.rs2_data     = $urandom;
        r.imm          = $urandom;
        r.rs1_addr     = 5'($urandom_range(0, 7));
        r.rs2_addr     = 5'($urandom_range(0, 7));
        r.rd_addr      = 5'($urandom);
        r.alu_op       = 4'($urandom_range(0, 9));
        r.src_b_imm    = 1'($urandom);
        r.reg_we       = 1'($urandom);
        r.exmem_we     = 1'($urandom);
        r.exmem_rd     = 5'($urandom_range(0, 7));
        r.exmem_result = $urandom;
        r.memwb_we     = 1'($urandom);
        r.memwb_rd     = 5'($urandom_range(0, 7));
        r.memwb_result = $urandom;
        return r;
    endfunction

    task automatic applyStimulus(input id_in_t in, input logic stall, input logic flush);
        cur_in         = in;
        cur_stall      = stall;
        cur_flush      = flush;
        stall_i        = stall;
        flush_i        = flush;
        id_valid_i     = in.valid;
        id_pc_i        = in.pc;
        id_rs1_data_i  = in.rs1_data;
        id_rs2_data_i  = in.rs2_data;
        id_imm_i       = in.imm;
        id_rs1_addr_i  = in.rs1_addr;
        id_rs2_addr_i  = in.rs2_addr;
        id_rd_addr_i   = in.rd_addr;
        id_alu_op_i    = in.alu_op;
        id_src_b_imm_i = in.src_b_imm;
        id_reg_we_i    = in.reg_we;
        exmem_we_i     = in.exmem_we;
        exmem_rd_i     = in.exmem_rd;
        exmem_result_i = in.exmem_result;
        memwb_we_i     = in.memwb_we;
        memwb_rd_i     = in.memwb_rd;
        memwb_result_i = in.memwb_result;
    endtask

    // Advance one edge and keep the reference state in step with it
    task automatic stepEdge();
        @(posedge clk_i);
        #1;
        if (rst_i) model = '0;
        else model = model_next(model, cur_in, cur_stall, cur_flush);
    endtask

    task automatic checkField(input string name, input string field,
                              input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s.%s got %h expected %h", name, field, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input ex_state_t exp);
        checkField(name, "valid", 32'(ex_valid_o), 32'(exp.valid));
        checkField(name, "pc", ex_pc_o, exp.pc);
        checkField(name, "a", ex_a_o, exp.a);
        checkField(name, "b", ex_b_o, exp.b);
        checkField(name, "store", ex_store_data_o, exp.store);
        checkField(name, "rd", 32'(ex_rd_addr_o), 32'(exp.rd));
        checkField(name, "op", 32'(ex_alu_op_o), 32'(exp.op));
        checkField(name, "we", 32'(ex_reg_we_o), 32'(exp.we));
    endtask

    initial begin
        ex_state_t held;
        ex_state_t zero_state;
        id_in_t    load_in;
        zero_state = '0;

        // Directed vectors with hand-derived expected outputs
        vecs[0].name = "plain_load";
        vecs[0].in   = make_in(1, 32'h100, 32'h10, 32'h3, 32'h0, 5'd1, 5'd2, 5'd3, ALU_ADD, 0, 1,
                               0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        vecs[0].exp  = make_exp(1, 32'h100, 32'h10, 32'h3, 32'h3, 5'd3, ALU_ADD, 1);
        vecs[1].name = "fwd_priority";
        vecs[1].in   = make_in(1, 32'h104, 32'h1111, 32'h22, 32'h0, 5'd5, 5'd6, 5'd7, ALU_ADD, 0, 1,
                               1, 5'd5, 32'hAAAA_0000, 1, 5'd5, 32'h5555_0000);
        vecs[1].exp  = make_exp(1, 32'h104, 32'hAAAA_0000, 32'h22, 32'h22, 5'd7, ALU_ADD, 1);
        vecs[2].name = "x0_guard";
        vecs[2].in   = make_in(1, 32'h108, 32'h0, 32'h7, 32'h0, 5'd0, 5'd2, 5'd4, ALU_SUB, 0, 1,
                               1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'h1234_5678);
        vecs[2].exp  = make_exp(1, 32'h108, 32'h0, 32'h7, 32'h7, 5'd4, ALU_SUB, 1);
        vecs[3].name = "shift_mask_sll";
        vecs[3].in   = make_in(1, 32'h10C, 32'h9, 32'h40, 32'hFFFF_FFE5, 5'd1, 5'd2, 5'd8, ALU_SLL, 1, 1,
                               0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        vecs[3].exp  = make_exp(1, 32'h10C, 32'h9, 32'h5, 32'h40, 5'd8, ALU_SLL, 1);
        vecs[4].name = "no_mask_add";
        vecs[4].in   = make_in(1, 32'h10C, 32'h9, 32'h40, 32'hFFFF_FFE5, 5'd1, 5'd2, 5'd8, ALU_ADD, 1, 1,
                               0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        vecs[4].exp  = make_exp(1, 32'h10C, 32'h9, 32'hFFFF_FFE5, 32'h40, 5'd8, ALU_ADD, 1);
        vecs[5].name = "memwb_fwd_sra";
        vecs[5].in   = make_in(1, 32'h110, 32'h8000_0000, 32'h0, 32'h0, 5'd3, 5'd9, 5'd10, ALU_SRA, 0, 1,
                               1, 5'd4, 32'hDEAD_BEEF, 1, 5'd9, 32'h0000_0123);
        vecs[5].exp  = make_exp(1, 32'h110, 32'h8000_0000, 32'h3, 32'h123, 5'd10, ALU_SRA, 1);
        vecs[6].name = "invalid_instr";
        vecs[6].in   = make_in(0, 32'h114, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2, 5'd11, ALU_XOR, 0, 1,
                               0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        vecs[6].exp  = make_exp(0, 32'h114, 32'h5, 32'h6, 32'h6, 5'd11, ALU_XOR, 0);
        vecs[7].name = "no_write";
        vecs[7].in   = make_in(1, 32'h118, 32'hA, 32'hB, 32'h0, 5'd1, 5'd2, 5'd12, ALU_OR, 0, 0,
                               0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        vecs[7].exp  = make_exp(1, 32'h118, 32'hA, 32'hB, 32'hB, 5'd12, ALU_OR, 0);

        // Reset state
        rst_i = 1'b1;
        applyStimulus(vecs[0].in, 0, 0);
        model = '0;
        #2;
        checkOutput("reset_state", zero_state);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Table-driven directed loads
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].in, 0, 0);
            stepEdge();
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Stall for three cycles while ID keeps changing: outputs frozen
        applyStimulus(vecs[0].in, 0, 0);
        stepEdge();
        held = vecs[0].exp;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(random_in(), 1, 0);
            stepEdge();
            checkOutput("stall_hold", held);
        end

        // Stall released: next load proceeds normally
        applyStimulus(vecs[3].in, 0, 0);
        stepEdge();
        checkOutput("stall_release", vecs[3].exp);

        // Flush together with stall loads a bubble
        applyStimulus(vecs[1].in, 1, 1);
        stepEdge();
        checkOutput("flush_over_stall", zero_state);

        // Asynchronous reset asserted mid-cycle with a valid instruction held
        applyStimulus(vecs[1].in, 0, 0);
        stepEdge();
        checkOutput("pre_reset_load", vecs[1].exp);
        #2;
        rst_i = 1'b1;
        #1;
        model = '0;
        checkOutput("async_reset", zero_state);
        stepEdge();
        checkOutput("reset_held", zero_state);
        #2;
        rst_i = 1'b0;
        applyStimulus(vecs[5].in, 0, 0);
        stepEdge();
        checkOutput("after_reset", vecs[5].exp);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            load_in = random_in();
            applyStimulus(load_in, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
            stepEdge();
            checkOutput("random", model);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
